// File: rtl/output_deskew_buffer_if.sv
// Bus bundle between the array's bottom PE row and the deskew buffer.
// master drives partial sums and control; slave returns the aligned vectors.
interface output_deskew_buffer_if #(
    parameter int SYSTOLIC_SIZE = 8,
    parameter int PSUM_WIDTH    = 24,
    parameter int CNT_WIDTH     = 8
);
    logic                                test_mode;
    logic                                clear;
    logic                                psum_valid_in;
    logic [SYSTOLIC_SIZE*PSUM_WIDTH-1:0] psum_in;
    logic                                out_valid;
    logic [SYSTOLIC_SIZE*PSUM_WIDTH-1:0] out_data;
    logic [CNT_WIDTH-1:0]                out_count;
    logic                                busy;

    modport master (
        output test_mode, clear, psum_valid_in, psum_in,
        input  out_valid, out_data, out_count, busy
    );

    modport slave (
        input  test_mode, clear, psum_valid_in, psum_in,
        output out_valid, out_data, out_count, busy
    );
endinterface

// File: rtl/output_deskew_buffer.sv
// Re-aligns 45-degree skewed partial-sum columns into one parallel word.
// Column j waits SYSTOLIC_SIZE-1-j cycles so every column meets the last one.
module output_deskew_buffer #(
    parameter int SYSTOLIC_SIZE = 8,
    parameter int PSUM_WIDTH    = 24,
    parameter int CNT_WIDTH     = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    output_deskew_buffer_if.slave  bus
);
    localparam int S  = SYSTOLIC_SIZE;
    localparam int W  = PSUM_WIDTH;
    localparam int VW = S * W;

    logic [VW-1:0]        skew_data;
    logic [S-2:0]         vpipe_q, vpipe_d;
    logic                 tmode_q, tmode_d;
    logic                 out_valid_q, out_valid_d;
    logic [VW-1:0]        out_data_q, out_data_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 mode_chg;
    logic                 algn_valid;
    logic [VW-1:0]        algn_data;

    for (genvar j = 0; j < S; j++) begin : g_col
        localparam int D = S - 1 - j;
        if (D == 0) begin : g_nodly
            assign skew_data[j*W +: W] = bus.psum_in[j*W +: W];
        end else begin : g_dly
            logic [W-1:0] sh_q [D];
            logic [W-1:0] sh_d [D];

            always_comb begin
                sh_d[0] = bus.clear ? '0 : bus.psum_in[j*W +: W];
                for (int k = 1; k < D; k++)
                    sh_d[k] = bus.clear ? '0 : sh_q[k-1];
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int k = 0; k < D; k++)
                        sh_q[k] <= '0;
                end else begin
                    sh_q <= sh_d;
                end
            end

            assign skew_data[j*W +: W] = sh_q[D-1];
        end
    end

    // A mode switch in this cycle kills everything still in flight.
    assign mode_chg   = bus.test_mode ^ tmode_q;
    assign algn_valid = !mode_chg &&
                        (bus.test_mode ? bus.psum_valid_in
                                       : vpipe_q[S-2]);
    assign algn_data  = bus.test_mode ? bus.psum_in : skew_data;

    always_comb begin
        tmode_d     = bus.test_mode;
        vpipe_d     = '0;
        out_valid_d = 1'b0;
        out_data_d  = out_data_q;
        cnt_d       = cnt_q;
        if (bus.clear) begin
            out_data_d = '0;
            cnt_d      = '0;
        end else begin
            if (!bus.test_mode && !mode_chg) begin
                vpipe_d    = vpipe_q << 1;
                vpipe_d[0] = bus.psum_valid_in;
            end
            out_valid_d = algn_valid;
            if (algn_valid)
                out_data_d = algn_data;
            if (out_valid_q && cnt_q != '1)
                cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vpipe_q     <= '0;
            tmode_q     <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            cnt_q       <= '0;
        end else begin
            vpipe_q     <= vpipe_d;
            tmode_q     <= tmode_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            cnt_q       <= cnt_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_count = cnt_q;
    assign bus.busy      = (|vpipe_q) && !bus.test_mode;
endmodule

// File: tb/tb_output_deskew_buffer.sv
// Bench for output_deskew_buffer: directed flush/boundary sequences,
// a test-mode vector table, and randomized traffic against a vector model.
module tb_output_deskew_buffer;
    localparam int S  = 8;
    localparam int W  = 24;
    localparam int VW = S * W;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    output_deskew_buffer_if #(.SYSTOLIC_SIZE(S), .PSUM_WIDTH(W),
                              .CNT_WIDTH(8)) ai ();
    output_deskew_buffer_if #(.SYSTOLIC_SIZE(S), .PSUM_WIDTH(W),
                              .CNT_WIDTH(4)) bi ();

    assign bi.test_mode     = ai.test_mode;
    assign bi.clear         = ai.clear;
    assign bi.psum_valid_in = ai.psum_valid_in;
    assign bi.psum_in       = ai.psum_in;

    output_deskew_buffer #(.SYSTOLIC_SIZE(S), .PSUM_WIDTH(W),
                           .CNT_WIDTH(8)) u_a (
        .clk(clk), .rst_n(rst_n), .bus(ai));
    output_deskew_buffer #(.SYSTOLIC_SIZE(S), .PSUM_WIDTH(W),
                           .CNT_WIDTH(4)) u_b (
        .clk(clk), .rst_n(rst_n), .bus(bi));

    typedef struct {
        logic         clr;
        logic         vin;
        logic [W-1:0] val;
        logic         ev;
        logic [W-1:0] ed;
    } tv_t;

    int n_chk  = 0;
    int n_pass = 0;
    int e      = 0;
    bit manual = 0;

    logic [VW-1:0] launch [int];
    logic [VW-1:0] hist   [int];
    int            pend   [$];
    bit            m_valid;
    bit            m_prev_tm;
    logic [VW-1:0] m_data;
    int            m_cnt;
    int            m_cntb;

    task automatic chk(input string nm, input logic [VW-1:0] act,
                       input logic [VW-1:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", nm, act, exp);
    endtask

    function automatic logic [VW-1:0] mkvec(input int base);
        logic [VW-1:0] r;
        for (int j = 0; j < S; j++) r[j*W +: W] = W'(base + j);
        return r;
    endfunction

    function automatic logic [VW-1:0] fill(input logic [W-1:0] v);
        logic [VW-1:0] r;
        for (int j = 0; j < S; j++) r[j*W +: W] = v;
        return r;
    endfunction

    function automatic logic [VW-1:0] rvec();
        logic [VW-1:0] r;
        for (int j = 0; j < S; j++) r[j*W +: W] = W'($urandom);
        return r;
    endfunction

    function automatic void model_reset();
        pend.delete();
        m_valid   = 0;
        m_prev_tm = 0;
        m_data    = '0;
        m_cnt     = 0;
        m_cntb    = 0;
    endfunction

    // Vector-level model: a vector sampled at edge t shows up after edge
    // t+S-1 built from column j of the word sampled at edge t+j.
    function automatic void model_edge();
        logic [VW-1:0] v;
        logic [VW-1:0] tmp;
        bit tm;
        bit chg;
        tm = ai.test_mode;
        chg = (tm != m_prev_tm);
        m_prev_tm = tm;
        hist[e] = ai.psum_in;
        if (ai.clear) begin
            pend.delete();
            m_valid = 0;
            m_data  = '0;
            m_cnt   = 0;
            m_cntb  = 0;
            return;
        end
        if (m_valid) begin
            if (m_cnt < 255) m_cnt++;
            if (m_cntb < 15) m_cntb++;
        end
        m_valid = 0;
        if (chg) begin
            pend.delete();
        end else if (tm) begin
            if (ai.psum_valid_in) begin
                m_valid = 1;
                m_data  = ai.psum_in;
            end
        end else begin
            if (ai.psum_valid_in) pend.push_back(e);
            if (pend.size() > 0 && pend[0] + S - 1 == e) begin
                for (int j = 0; j < S; j++) begin
                    tmp = hist[pend[0] + j];
                    v[j*W +: W] = tmp[j*W +: W];
                end
                m_data  = v;
                m_valid = 1;
                void'(pend.pop_front());
            end
        end
    endfunction

    task automatic check_all();
        bit m_busy;
        m_busy = (pend.size() != 0) && !ai.test_mode;
        chk("out_valid", VW'(ai.out_valid), VW'(m_valid));
        chk("out_data", ai.out_data, m_data);
        chk("out_count", VW'(ai.out_count), VW'(m_cnt));
        chk("busy", VW'(ai.busy), VW'(m_busy));
        chk("out_valid_c4", VW'(bi.out_valid), VW'(m_valid));
        chk("out_count_c4", VW'(bi.out_count), VW'(m_cntb));
    endtask

    task automatic drive_auto();
        logic [VW-1:0] p;
        logic [VW-1:0] v;
        for (int j = 0; j < S; j++) begin
            if (launch.exists(e - j)) begin
                v = launch[e - j];
                p[j*W +: W] = v[j*W +: W];
            end else begin
                p[j*W +: W] = W'($urandom);
            end
        end
        ai.psum_in       = p;
        ai.psum_valid_in = (launch.exists(e) != 0);
    endtask

    task automatic step();
        if (!manual) drive_auto();
        @(posedge clk);
        model_edge();
        e++;
        #1;
        check_all();
    endtask

    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_valid", VW'(ai.out_valid), '0);
        chk("rst_data", ai.out_data, '0);
        chk("rst_count", VW'(ai.out_count), '0);
        chk("rst_busy", VW'(ai.busy), '0);
        model_reset();
        @(posedge clk);
        e++;
        #1;
        rst_n = 1'b1;
    endtask

    task automatic send_and_check(input logic [VW-1:0] v, input string nm);
        launch[e] = v;
        for (int i = 0; i < S; i++) step();
        chk({nm, "_valid"}, VW'(ai.out_valid), VW'(1));
        chk({nm, "_data"}, ai.out_data, v);
    endtask

    task automatic pulse_clear();
        ai.clear = 1'b1;
        step();
        ai.clear = 1'b0;
    endtask

    initial begin
        tv_t           tv [7];
        logic [VW-1:0] got [$];
        int            first_p;
        int            last_p;
        int            npb;
        bit            seen;

        tv[0] = '{1'b0, 1'b1, 24'hA5A5A5, 1'b1, 24'hA5A5A5};
        tv[1] = '{1'b0, 1'b0, 24'h123456, 1'b0, 24'hA5A5A5};
        tv[2] = '{1'b0, 1'b1, 24'h0F0F0F, 1'b1, 24'h0F0F0F};
        tv[3] = '{1'b0, 1'b1, 24'hFFFFFF, 1'b1, 24'hFFFFFF};
        tv[4] = '{1'b1, 1'b1, 24'h111111, 1'b0, 24'h000000};
        tv[5] = '{1'b0, 1'b0, 24'h222222, 1'b0, 24'h000000};
        tv[6] = '{1'b0, 1'b1, 24'h333333, 1'b1, 24'h333333};

        ai.test_mode     = 1'b0;
        ai.clear         = 1'b0;
        ai.psum_valid_in = 1'b0;
        ai.psum_in       = '0;
        @(posedge clk);
        #1;
        do_reset();

        // skew ramp: single pulse exactly after edge t+S-1
        launch[e] = mkvec(100);
        for (int i = 0; i < S; i++) begin
            step();
            if (i < S - 1)
                chk("ramp_early", VW'(ai.out_valid), '0);
        end
        chk("ramp_valid", VW'(ai.out_valid), VW'(1));
        chk("ramp_data", ai.out_data, mkvec(100));
        step();
        chk("ramp_pulse", VW'(ai.out_valid), '0);
        chk("ramp_count", VW'(ai.out_count), VW'(1));

        // idle hold
        for (int i = 0; i < 20; i++) begin
            step();
            chk("idle_valid", VW'(ai.out_valid), '0);
            chk("idle_data", ai.out_data, mkvec(100));
        end

        // back-to-back stream
        pulse_clear();
        for (int k = 0; k < 16; k++) launch[e + k] = mkvec(k * 16);
        first_p = -1;
        last_p = -1;
        for (int i = 0; i < 16 + S; i++) begin
            step();
            if (ai.out_valid) begin
                got.push_back(ai.out_data);
                if (first_p < 0) first_p = i;
                last_p = i;
            end
        end
        chk("b2b_n", VW'(got.size()), VW'(16));
        chk("b2b_span", VW'(last_p - first_p), VW'(15));
        for (int k = 0; k < 16 && k < got.size(); k++)
            chk("b2b_order", got[k], mkvec(k * 16));
        chk("b2b_busy", VW'(ai.busy), '0);
        chk("b2b_count", VW'(ai.out_count), VW'(16));

        // clear hits a vector with 3 columns sent
        launch[e] = mkvec(200);
        for (int i = 0; i < 3; i++) step();
        pulse_clear();
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (ai.out_valid) seen = 1;
        end
        chk("clr_novalid", VW'(seen), '0);
        chk("clr_count", VW'(ai.out_count), '0);
        send_and_check(mkvec(300), "clr_next");
        step();

        // test_mode toggle drops the in-flight vector
        launch[e] = mkvec(400);
        for (int i = 0; i < 3; i++) step();
        ai.test_mode = 1'b1;
        step();
        ai.test_mode = 1'b0;
        step();
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (ai.out_valid) seen = 1;
        end
        chk("tgl_novalid", VW'(seen), '0);
        chk("tgl_count", VW'(ai.out_count), VW'(1));
        send_and_check(mkvec(500), "tgl_next");

        // asynchronous reset mid-flight
        launch[e] = mkvec(600);
        for (int i = 0; i < 3; i++) step();
        do_reset();
        send_and_check(mkvec(700), "rst_next");
        step();

        // test-mode table
        manual = 1;
        ai.test_mode = 1'b1;
        ai.psum_valid_in = 1'b0;
        step();
        for (int i = 0; i < 7; i++) begin
            ai.clear = tv[i].clr;
            ai.psum_valid_in = tv[i].vin;
            ai.psum_in = fill(tv[i].val);
            step();
            chk("tm_valid", VW'(ai.out_valid), VW'(tv[i].ev));
            chk("tm_data", ai.out_data, fill(tv[i].ed));
            chk("tm_busy", VW'(ai.busy), '0);
        end
        ai.clear = 1'b0;
        ai.psum_valid_in = 1'b0;
        ai.test_mode = 1'b0;
        step();
        manual = 0;

        // saturation of the 4-bit counter
        pulse_clear();
        for (int k = 0; k < 20; k++) launch[e + k] = mkvec(1000 + k * 8);
        npb = 0;
        for (int i = 0; i < 20 + S + 1; i++) begin
            step();
            if (bi.out_valid) npb++;
        end
        chk("sat_pulses", VW'(npb), VW'(20));
        chk("sat_count4", VW'(bi.out_count), VW'(15));
        chk("sat_count8", VW'(ai.out_count), VW'(20));

        // random normal-mode traffic with occasional clear
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(2) == 0 && !launch.exists(e))
                launch[e] = rvec();
            ai.clear = ($urandom_range(39) == 0);
            step();
        end
        ai.clear = 1'b0;
        for (int i = 0; i < S; i++) step();

        // random test-mode traffic
        manual = 1;
        ai.psum_valid_in = 1'b0;
        ai.test_mode = 1'b1;
        step();
        for (int i = 0; i < 100; i++) begin
            ai.psum_in = rvec();
            ai.psum_valid_in = $urandom_range(1) != 0;
            ai.clear = ($urandom_range(29) == 0);
            step();
        end
        ai.clear = 1'b0;
        ai.psum_valid_in = 1'b0;
        ai.test_mode = 1'b0;
        step();
        manual = 0;
        for (int i = 0; i < S; i++) step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/output_deskew_buffer.md
# output_deskew_buffer

Output-side counterpart of the activation skew buffer. Captures partial-sum vectors leaving the bottom of the SYSTOLIC_SIZE×SYSTOLIC_SIZE array in the 45-degree skewed order and re-aligns them into one parallel word per result row. Column j arrives j cycles after column 0. Sits between the array's bottom PE row and the result writeback / self-test comparator. It also supports a test-mode bypass for parallel (unskewed) capture.

## Interface
- SYSTOLIC_SIZE, 8, array dimension (number of columns), ≥2
- PSUM_WIDTH, 24, bits per partial sum
- CNT_WIDTH, 8, width of the emitted-vector counter
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- test_mode  in  1  0: skewed input (normal), 1: all columns aligned (parallel test capture)
- clear  in  1  synchronous flush of pipeline, outputs and counter
- psum_valid_in  in  1  column-0 element of a result vector present this cycle
- psum_in  in  SYSTOLIC_SIZE*PSUM_WIDTH  column j at bits [j*PSUM_WIDTH +: PSUM_WIDTH]
- out_valid  out  1  out_data holds a newly aligned vector this cycle (1-cycle pulse per vector)
- out_data  out  SYSTOLIC_SIZE*PSUM_WIDTH  aligned vector, same column packing as psum_in
- out_count  out  CNT_WIDTH  vectors emitted since reset/clear, saturating
- busy  out  1  at least one vector in flight inside the deskew pipeline

## Operation
- Deskew: column j passes through D(j)=SYSTOLIC_SIZE-1-j delay registers. Column SYSTOLIC_SIZE-1 has none. Delay registers shift every cycle, independent of valid.
- Valid tracking: a SYSTOLIC_SIZE-1 deep shift register carries psum_valid_in. Its tail marks the cycle when all columns of one vector are aligned at the output-register input.
- Output register: all columns registered in parallel. out_data loads only when the aligned valid is 1, and holds otherwise. out_valid is a registered copy of the aligned valid.
- Test mode: delay chains and the valid shift register are bypassed. psum_in and psum_valid_in feed the output register directly.
- test_mode change: when test_mode differs from its value in the previous cycle, the valid shift register is cleared. Vectors in flight are dropped and never produce out_valid. Data registers are not cleared.
- out_count: increments by 1 in the cycle after each out_valid pulse. Holds at 2^CNT_WIDTH-1.
- busy: OR of the valid shift register bits (normal mode). Always 0 in test_mode.
- clear: on the next edge, zeroes delay registers, valid pipe, out_data, out_valid and out_count. psum_valid_in sampled in the same cycle as clear is discarded. clear has priority over all other updates.
- Reset (any time, including mid-operation): every register is 0. Outputs are out_valid=0, out_data=0, out_count=0, busy=0.

## Timing
- Normal mode: column 0 sampled at edge t with psum_valid_in=1, and column j sampled at edge t+j. The aligned vector appears on out_data with out_valid=1 during the cycle after edge t+SYSTOLIC_SIZE-1, i.e. latency SYSTOLIC_SIZE edges from the column-0 sample.
- Test mode: latency 1 edge. Inputs sampled at edge t appear in the cycle after edge t.
- Back-to-back: psum_valid_in high for N consecutive cycles yields N consecutive out_valid pulses with no bubbles. Throughput is 1 vector/cycle.
- busy asserts the cycle after the first valid sample. It deasserts the same cycle the last vector's out_valid asserts.
- Simultaneous clear and an aligned valid: clear wins, no out_valid, and the counter does not increment.

## Test plan
- Skew ramp (SYSTOLIC_SIZE=8, normal): column j driven with 100+j at edge t+j and garbage at other cycles, psum_valid_in=1 only at t. Required: out_valid single pulse after edge t+7, out_data columns = 100..107, out_count=1.
- Back-to-back stream: 16 consecutive vectors, vector k column j = k*16+j, each skewed. Required: 16 consecutive out_valid pulses in order, busy low after the last, out_count=16.
- Test-mode parallel: test_mode=1, psum_in all columns = 0xA5A5A5, valid for one cycle. Required: out_valid one cycle later with matching data, busy stays 0.
- Flush events: a vector in flight (3 columns sent) is hit by clear. Required: no out_valid, out_count=0, and the next full vector is aligned correctly. Repeat with a test_mode toggle instead (vector dropped, count unchanged) and with an rst_n pulse (all outputs 0 immediately).
- Counter saturation (CNT_WIDTH=4): 20 vectors. Required: out_count stops at 15 while out_valid continues pulsing.
- Idle hold: after a vector, drive random psum_in with psum_valid_in=0 for 20 cycles. Required: out_data unchanged, out_valid=0.
